instr_mem_loadable: RTL and testbench

Parametrised, loadable instruction memory for the MIPS16 core and its wider variants. It replaces a fixed, combinational initial-block ROM with a synchronous-read array that returns an instruction one cycle after each fetch request. A byte-serial load port lets a host or bootloader rewrite the program at run time, and an address-fault flag reports fetches that fall outside the array.

---
 rtl/instr_mem_loadable.sv | 168 ++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: synchronous one-cycle fetch, byte-serial program
// load port, and an address-fault flag for fetches beyond the array.
module instr_mem_loadable #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [PC_W-1:0]        pc,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   instr_valid,
    output logic                   addr_fault,
    output logic                   fetch_stall,
    input  logic                   ld_start,
    input  logic [$clog2(DEPTH):0] ld_count,
    input  logic                   ld_byte_valid,
    input  logic [7:0]             ld_byte,
    output logic                   ld_busy,
    output logic                   ld_done
);
    localparam int BYTES = INSTR_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(BYTES);
    localparam int BCW   = (BW > 0) ? BW : 1;
    localparam longint unsigned FETCH_LIMIT = longint'(DEPTH) * longint'(BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    ld_state_t          r_state;
    logic [AW:0]        r_n;
    logic [AW:0]        r_waddr;
    logic [BCW-1:0]     r_bcnt;
    logic [INSTR_W-1:0] r_asm;
    logic               r_ld_busy;
    logic               r_ld_done;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_instruction;
    logic               r_instr_valid;
    logic               r_addr_fault;

    logic [AW:0]        w_ld_count_clamped;
    logic [AW:0]        w_waddr_next;
    logic               w_last_byte;
    logic               w_we;
    logic [INSTR_W-1:0] w_wdata;
    logic               w_fetch_accept;
    logic               w_in_range;
    logic [AW-1:0]      w_word_idx;

    // Load-side decode: clamp request length, detect word completion, build write data.
    always_comb begin
        w_ld_count_clamped = ld_count;
        if (ld_count > (AW+1)'(DEPTH)) begin
            w_ld_count_clamped = (AW+1)'(DEPTH);
        end else begin
            w_ld_count_clamped = ld_count;
        end
        w_waddr_next = r_waddr + 1'b1;
        w_last_byte  = (r_bcnt == BCW'(BYTES - 1));
        w_we         = (r_state == ST_RECV) && ld_byte_valid && w_last_byte;
        // The top byte of r_asm is always clear, so the final byte can be OR-ed in.
        w_wdata      = r_asm | (INSTR_W'(ld_byte) << (INSTR_W - 8));
    end

    // Fetch-side decode: acceptance, range check and word index.
    always_comb begin
        w_fetch_accept = fetch_req && (r_state == ST_IDLE) && !ld_start;
        w_in_range     = (64'(pc) < FETCH_LIMIT);
        w_word_idx     = AW'(pc >> BW);
    end

    // Load FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_waddr   <= '0;
            r_bcnt    <= '0;
            r_asm     <= '0;
            r_ld_busy <= 1'b0;
            r_ld_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_n       <= w_ld_count_clamped;
                        r_waddr   <= '0;
                        r_bcnt    <= '0;
                        r_asm     <= '0;
                        r_ld_busy <= 1'b1;
                        if (w_ld_count_clamped == '0) begin
                            r_state   <= ST_DONE;
                            r_ld_done <= 1'b1;
                        end else begin
                            r_state   <= ST_RECV;
                            r_ld_done <= 1'b0;
                        end
                    end else begin
                        r_ld_busy <= 1'b0;
                        r_ld_done <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (ld_byte_valid) begin
                        if (w_last_byte) begin
                            r_waddr <= w_waddr_next;
                            r_bcnt  <= '0;
                            r_asm   <= '0;
                            if (w_waddr_next == r_n) begin
                                r_state   <= ST_DONE;
                                r_ld_done <= 1'b1;
                            end
                        end else begin
                            r_asm[{r_bcnt, 3'b000} +: 8] <= ld_byte;
                            r_bcnt                       <= r_bcnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_ld_busy <= 1'b0;
                    r_ld_done <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ld_busy <= 1'b0;
                    r_ld_done <= 1'b0;
                end
            endcase
        end
    end

    // Program storage; kept out of the reset domain so a reset never erases a program.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_waddr[AW-1:0]] <= w_wdata;
        end
    end

    // Registered fetch pipeline: one request per cycle, result one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_instruction <= w_in_range ? r_mem[w_word_idx] : '0;
                r_addr_fault  <= !w_in_range;
            end
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign addr_fault  = r_addr_fault;
    assign ld_busy     = r_ld_busy;
    assign ld_done     = r_ld_done;
    assign fetch_stall = r_ld_busy | ld_start;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised + directed bench for instr_mem_loadable against a byte-stream
// reference model; also exercises a 32-bit / 64-word instance.
module tb_instr_mem_loadable;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        fetch_req;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        instr_valid, addr_fault, fetch_stall;
    logic        ld_start;
    logic [4:0]  ld_count;
    logic        ld_byte_valid;
    logic [7:0]  ld_byte;
    logic        ld_busy, ld_done;

    logic        fetch_req_w;
    logic [31:0] pc_w;
    logic [31:0] instruction_w;
    logic        instr_valid_w, addr_fault_w, fetch_stall_w;
    logic        ld_start_w;
    logic [6:0]  ld_count_w;
    logic        ld_byte_valid_w;
    logic [7:0]  ld_byte_w;
    logic        ld_busy_w, ld_done_w;

    instr_mem_loadable #(.PC_W(16), .INSTR_W(16), .DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .instruction(instruction), .instr_valid(instr_valid), .addr_fault(addr_fault),
        .fetch_stall(fetch_stall), .ld_start(ld_start), .ld_count(ld_count),
        .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    instr_mem_loadable #(.PC_W(32), .INSTR_W(32), .DEPTH(64)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req_w), .pc(pc_w),
        .instruction(instruction_w), .instr_valid(instr_valid_w), .addr_fault(addr_fault_w),
        .fetch_stall(fetch_stall_w), .ld_start(ld_start_w), .ld_count(ld_count_w),
        .ld_byte_valid(ld_byte_valid_w), .ld_byte(ld_byte_w), .ld_busy(ld_busy_w), .ld_done(ld_done_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory image plus progress of the current byte stream.
    logic [15:0] m_mem [16];
    int          m_bytes_left;
    int          m_got;
    bit          m_done;
    logic [7:0]  m_low;
    logic [15:0] m_last;
    bit          m_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; pc = 16'd0; ld_start = 1'b0; ld_count = 5'd0;
        ld_byte_valid = 1'b0; ld_byte = 8'd0;
        fetch_req_w = 1'b0; pc_w = 32'd0; ld_start_w = 1'b0; ld_count_w = 7'd0;
        ld_byte_valid_w = 1'b0; ld_byte_w = 8'd0;
    endtask

    task automatic hard_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", ld_busy, 1'b0);
        check_eq("rst_done", ld_done, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instruction, 16'd0);
        check_eq("rst_fault", addr_fault, 1'b0);
        check_eq("rst_busy_w", ld_busy_w, 1'b0);
        check_eq("rst_valid_w", instr_valid_w, 1'b0);
        m_bytes_left = 0; m_got = 0; m_done = 1'b0; m_last = 16'd0; m_fault = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle on the 16-bit instance, checked against the model.
    task automatic step(input bit fr, input logic [15:0] p, input bit st,
                        input logic [4:0] cnt, input bit bv, input logic [7:0] b);
        bit idle;
        bit acc;
        int n;
        fetch_req = fr; pc = p; ld_start = st; ld_count = cnt;
        ld_byte_valid = bv; ld_byte = b;
        #1;
        idle = (m_bytes_left == 0) && !m_done;
        check_eq("fetch_stall", fetch_stall, (!idle) || st);
        acc = 1'b0;
        if (idle) begin
            if (st) begin
                n = (cnt > 5'd16) ? 16 : int'(cnt);
                m_bytes_left = n * 2;
                m_got = 0;
                m_done = (n == 0);
            end else begin
                acc = fr;
            end
        end else if (m_bytes_left > 0) begin
            if (bv) begin
                if (m_got % 2 == 1) m_mem[m_got / 2] = {b, m_low};
                else m_low = b;
                m_got++;
                m_bytes_left--;
                m_done = (m_bytes_left == 0);
            end
        end else begin
            m_done = 1'b0;
        end
        if (acc) begin
            m_fault = (p >= 16'd32);
            m_last  = m_fault ? 16'd0 : m_mem[p[4:1]];
        end
        @(posedge clk);
        #1;
        check_eq("instr_valid", instr_valid, acc);
        check_eq("instruction", instruction, m_last);
        check_eq("addr_fault", addr_fault, m_fault);
        check_eq("ld_busy", ld_busy, (m_bytes_left > 0) || m_done);
        check_eq("ld_done", ld_done, m_done);
    endtask

    task automatic tick_w();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rp;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'd0;
        idle_inputs();
        rst_n = 1'b0;
        ld_start = 1'b1;
        #1;
        check_eq("stall_in_reset", fetch_stall, 1'b1);
        check_eq("busy_in_reset", ld_busy, 1'b0);
        ld_start = 1'b0;
        #1;
        check_eq("stall_in_reset_low", fetch_stall, 1'b0);
        hard_reset();

        // Back-to-back fetches of an empty memory, then reset kills a pending result.
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd2, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd4, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd4, 1'b0, 5'd0, 1'b0, 8'd0);
        hard_reset();

        // Two-word load, then read back.
        step(1'b0, 16'd0, 1'b1, 5'd2, 1'b0, 8'd0);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h80);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h82);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h3F);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h35);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd2, 1'b0, 5'd0, 1'b0, 8'd0);
        check_eq("word1_after_load", instruction, 16'h353F);
        step(1'b1, 16'd32, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'hFFFE, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd3, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        check_eq("word0_after_load", instruction, 16'h8280);

        // Fetches collide with a load; a second start during RECV is ignored.
        step(1'b1, 16'd0, 1'b1, 5'd2, 1'b0, 8'd0);
        step(1'b1, 16'd2, 1'b0, 5'd0, 1'b1, 8'hA1);
        step(1'b1, 16'd4, 1'b1, 5'd1, 1'b1, 8'hA2);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd2, 1'b0, 5'd0, 1'b1, 8'hA3);
        step(1'b1, 16'd6, 1'b0, 5'd0, 1'b1, 8'hA4);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        check_eq("restart_ignored", instruction, 16'hA2A1);

        // Zero-length load.
        step(1'b0, 16'd0, 1'b1, 5'd0, 1'b0, 8'd0);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h99);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);

        // Oversized load clamps to 16 words; trailing bytes are ignored.
        step(1'b0, 16'd0, 1'b1, 5'd31, 1'b0, 8'd0);
        for (int i = 0; i < 32; i++) step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'($urandom));
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'hEE);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'hEF);
        for (int i = 0; i < 16; i++) step(1'b1, 16'(2 * i), 1'b0, 5'd0, 1'b0, 8'd0);

        // Reset in the middle of a load.
        step(1'b0, 16'd0, 1'b1, 5'd2, 1'b0, 8'd0);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h11);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h22);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h33);
        hard_reset();
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        check_eq("partial_word0", instruction, 16'h2211);
        step(1'b1, 16'd2, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b0, 16'd0, 1'b1, 5'd1, 1'b0, 8'd0);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h55);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b1, 8'h66);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        step(1'b1, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        check_eq("reload_word0", instruction, 16'h6655);
        step(1'b0, 16'd0, 1'b0, 5'd0, 1'b0, 8'd0);
        idle_inputs();

        // Wide instance: 4-byte assembly and its fault boundary.
        ld_start_w = 1'b1; ld_count_w = 7'd1;
        tick_w();
        ld_start_w = 1'b0;
        check_eq("w_busy", ld_busy_w, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            ld_byte_valid_w = 1'b1; ld_byte_w = 8'(i);
            tick_w();
        end
        ld_byte_valid_w = 1'b0;
        check_eq("w_done", ld_done_w, 1'b1);
        tick_w();
        check_eq("w_done_low", ld_done_w, 1'b0);
        check_eq("w_busy_low", ld_busy_w, 1'b0);
        fetch_req_w = 1'b1; pc_w = 32'd0;
        tick_w();
        check_eq("w_valid0", instr_valid_w, 1'b1);
        check_eq("w_instr0", instruction_w, 32'h04030201);
        check_eq("w_fault0", addr_fault_w, 1'b0);
        pc_w = 32'd256;
        tick_w();
        check_eq("w_instr256", instruction_w, 32'd0);
        check_eq("w_fault256", addr_fault_w, 1'b1);
        pc_w = 32'd252;
        tick_w();
        check_eq("w_fault252", addr_fault_w, 1'b0);
        fetch_req_w = 1'b0;
        tick_w();
        check_eq("w_valid_off", instr_valid_w, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                hard_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) rp = 16'($urandom);
                else rp = 16'($urandom_range(0, 40));
                step(1'($urandom_range(0, 1)), rp, ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0), 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
